// File: rtl/kitchen_timer.sv
// kitchen_timer
// Minutes:seconds kitchen timer with a four-digit multiplexed seven-segment display.
// The operator loads minutes/seconds from a switch bank, starts the timer, and lets it
// count up (saturating at 59:59) or down (stopping in DONE at 00:00).
//
// Ports:
//   clk         system clock (only clock)
//   reset       synchronous, active-high; overrides everything
//   minbtn      rising edge loads minutes from timesetter
//   secbtn      rising edge loads seconds from timesetter
//   pause       rising edge pauses a running timer
//   start       rising edge starts/resumes counting
//   count_up    level: 1 = count up, 0 = count down
//   zippy       level: 1 = fast step period (ZIP_CYCLES)
//   timesetter  load value, values above 59 load as 59
//   zled        high while the countdown has expired (DONE)
//   seven       segments {g,f,e,d,c,b,a}, active-low, registered
//   AN          digit anodes, active-low one-hot, AN[3]=minutes tens, AN[0]=seconds ones
module kitchen_timer #(
  parameter int TICK_CYCLES    = 100_000_000,
  parameter int ZIP_CYCLES     = 1_000_000,
  parameter int REFRESH_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       minbtn,
  input  logic       secbtn,
  input  logic       pause,
  input  logic       start,
  input  logic       count_up,
  input  logic       zippy,
  input  logic [5:0] timesetter,
  output logic       zled,
  output logic [6:0] seven,
  output logic [3:0] AN
);

  localparam int MAX_CYCLES = (TICK_CYCLES > ZIP_CYCLES) ? TICK_CYCLES : ZIP_CYCLES;
  localparam int PW = $clog2(MAX_CYCLES) + 1;
  localparam int RW = $clog2(REFRESH_CYCLES) + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUNNING = 2'd1;
  localparam logic [1:0] PAUSED  = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  // Clamp a switch value into the 0..59 range.
  function automatic logic [5:0] sat59(input logic [5:0] v);
    if (v > 6'd59) begin
      sat59 = 6'd59;
    end else begin
      sat59 = v;
    end
  endfunction

  // Tens digit of a 0..59 value, by comparison rather than division.
  function automatic logic [3:0] tens_of(input logic [5:0] v);
    if (v >= 6'd50) begin
      tens_of = 4'd5;
    end else if (v >= 6'd40) begin
      tens_of = 4'd4;
    end else if (v >= 6'd30) begin
      tens_of = 4'd3;
    end else if (v >= 6'd20) begin
      tens_of = 4'd2;
    end else if (v >= 6'd10) begin
      tens_of = 4'd1;
    end else begin
      tens_of = 4'd0;
    end
  endfunction

  // Ones digit of a 0..59 value.
  function automatic logic [3:0] ones_of(input logic [5:0] v);
    logic [5:0] t6;
    t6 = {2'b00, tens_of(v)};
    ones_of = 4'(v - (t6 * 6'd10));
  endfunction

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic          minbtn_q, secbtn_q, pause_q, start_q;
  logic [1:0]    state_q, state_d;
  logic [5:0]    min_q, min_d, sec_q, sec_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [RW-1:0] refresh_q, refresh_d;
  logic [1:0]    digit_q, digit_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seven_q, seven_d;
  logic          zled_q, zled_d;

  logic          min_edge_s, sec_edge_s, pause_edge_s, start_edge_s;
  logic [PW-1:0] limit_m1_s;
  logic          step_s;
  logic          hit_zero_s;
  logic [5:0]    load_val_s;
  logic [3:0]    bcd_s;

  assign min_edge_s   = minbtn & ~minbtn_q;
  assign sec_edge_s   = secbtn & ~secbtn_q;
  assign pause_edge_s = pause & ~pause_q;
  assign start_edge_s = start & ~start_q;

  // ">=" rather than "==" so that switching to zippy late in a long period steps at once.
  assign limit_m1_s = zippy ? PW'(ZIP_CYCLES - 1) : PW'(TICK_CYCLES - 1);
  assign step_s     = (state_q == RUNNING) && (presc_q >= limit_m1_s);
  assign load_val_s = sat59(timesetter);

  // Time value and FSM next-state logic.
  always_comb begin
    min_d      = min_q;
    sec_d      = sec_q;
    state_d    = state_q;
    hit_zero_s = 1'b0;
    case (state_q)
      IDLE, PAUSED: begin
        if (min_edge_s) begin
          min_d = load_val_s;
        end else begin
          min_d = min_q;
        end
        if (sec_edge_s) begin
          sec_d = load_val_s;
        end else begin
          sec_d = sec_q;
        end
        // Pause beats start when both edges arrive together.
        if (pause_edge_s) begin
          state_d = state_q;
        end else if (start_edge_s) begin
          state_d = RUNNING;
        end else begin
          state_d = state_q;
        end
      end
      RUNNING: begin
        if (step_s) begin
          if (count_up) begin
            if ((min_q == 6'd59) && (sec_q == 6'd59)) begin
              min_d = min_q;
              sec_d = sec_q;
            end else if (sec_q == 6'd59) begin
              sec_d = 6'd0;
              min_d = min_q + 6'd1;
            end else begin
              sec_d = sec_q + 6'd1;
            end
          end else begin
            if ((min_q == 6'd0) && (sec_q == 6'd0)) begin
              hit_zero_s = 1'b1;
            end else if (sec_q == 6'd0) begin
              sec_d = 6'd59;
              min_d = min_q - 6'd1;
            end else begin
              sec_d = sec_q - 6'd1;
              if ((min_q == 6'd0) && (sec_q == 6'd1)) begin
                hit_zero_s = 1'b1;
              end else begin
                hit_zero_s = 1'b0;
              end
            end
          end
        end else begin
          min_d = min_q;
          sec_d = sec_q;
        end
        if (hit_zero_s) begin
          state_d = DONE;
        end else if (pause_edge_s) begin
          state_d = PAUSED;
        end else begin
          state_d = RUNNING;
        end
      end
      DONE: begin
        if (min_edge_s) begin
          min_d = load_val_s;
        end else begin
          min_d = min_q;
        end
        if (sec_edge_s) begin
          sec_d = load_val_s;
        end else begin
          sec_d = sec_q;
        end
        if (min_edge_s || sec_edge_s) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Prescaler: runs only while staying in RUNNING, restarts on every start edge.
  always_comb begin
    presc_d = '0;
    if (start_edge_s) begin
      presc_d = '0;
    end else if ((state_q == RUNNING) && (state_d == RUNNING)) begin
      if (step_s) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d = '0;
    end
  end

  // Display scan counter and registered digit/anode/LED outputs.
  always_comb begin
    refresh_d = refresh_q + RW'(1);
    digit_d   = digit_q;
    if (refresh_q == RW'(REFRESH_CYCLES - 1)) begin
      refresh_d = '0;
      digit_d   = digit_q + 2'd1;
    end else begin
      refresh_d = refresh_q + RW'(1);
      digit_d   = digit_q;
    end
    case (digit_q)
      2'd0:    bcd_s = ones_of(sec_q);
      2'd1:    bcd_s = tens_of(sec_q);
      2'd2:    bcd_s = ones_of(min_q);
      2'd3:    bcd_s = tens_of(min_q);
      default: bcd_s = 4'd0;
    endcase
    an_d    = ~(4'b0001 << digit_q);
    seven_d = seg7(bcd_s);
    zled_d  = (state_d == DONE);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      minbtn_q  <= 1'b0;
      secbtn_q  <= 1'b0;
      pause_q   <= 1'b0;
      start_q   <= 1'b0;
      state_q   <= IDLE;
      min_q     <= 6'd0;
      sec_q     <= 6'd0;
      presc_q   <= '0;
      refresh_q <= '0;
      digit_q   <= 2'd0;
      an_q      <= 4'b1110;
      seven_q   <= 7'b1000000;
      zled_q    <= 1'b0;
    end else begin
      minbtn_q  <= minbtn;
      secbtn_q  <= secbtn;
      pause_q   <= pause;
      start_q   <= start;
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      presc_q   <= presc_d;
      refresh_q <= refresh_d;
      digit_q   <= digit_d;
      an_q      <= an_d;
      seven_q   <= seven_d;
      zled_q    <= zled_d;
    end
  end

  assign zled  = zled_q;
  assign seven = seven_q;
  assign AN    = an_q;

endmodule

// File: tb/tb_kitchen_timer.sv
module tb_kitchen_timer;
  localparam int TICK = 20;
  localparam int ZIP  = 4;
  localparam int REF  = 3;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk = 1'b0;
  logic       reset, minbtn, secbtn, pause, start, count_up, zippy;
  logic [5:0] timesetter;
  logic       zled;
  logic [6:0] seven;
  logic [3:0] AN;

  int checks = 0;
  int errors = 0;

  // Reference model: time as total seconds, mode, cycles spent in the current step
  // period, edges since reset, and last seen button levels.
  int   m_total, m_mode, m_el, m_k;
  logic p_min, p_sec, p_pause, p_start;

  kitchen_timer #(
    .TICK_CYCLES(TICK),
    .ZIP_CYCLES(ZIP),
    .REFRESH_CYCLES(REF)
  ) dut (
    .clk(clk), .reset(reset), .minbtn(minbtn), .secbtn(secbtn), .pause(pause),
    .start(start), .count_up(count_up), .zippy(zippy), .timesetter(timesetter),
    .zled(zled), .seven(seven), .AN(AN)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'b1000000;
      1: seg_of = 7'b1111001;
      2: seg_of = 7'b0100100;
      3: seg_of = 7'b0110000;
      4: seg_of = 7'b0011001;
      5: seg_of = 7'b0010010;
      6: seg_of = 7'b0000010;
      7: seg_of = 7'b1111000;
      8: seg_of = 7'b0000000;
      9: seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  function automatic int dig_of(input logic [6:0] s);
    dig_of = -1;
    for (int d = 0; d < 10; d++) begin
      if (seg_of(d) === s) dig_of = d;
    end
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: predict outputs from the model, advance it, then compare after the edge.
  task automatic tick();
    logic [3:0] e_an;
    logic [6:0] e_seven;
    int digs[4];
    int idx, nxt, lim, v, mm, ss;
    bit me, se, pe, ste, step;
    if (reset) begin
      e_an = 4'b1110; e_seven = 7'b1000000;
      m_total = 0; m_mode = M_IDLE; m_el = 0; m_k = 0;
      p_min = 1'b0; p_sec = 1'b0; p_pause = 1'b0; p_start = 1'b0;
    end else begin
      digs[0] = (m_total % 60) % 10;
      digs[1] = (m_total % 60) / 10;
      digs[2] = (m_total / 60) % 10;
      digs[3] = (m_total / 60) / 10;
      idx     = (m_k / REF) % 4;
      e_an    = ~(4'b0001 << idx);
      e_seven = seg_of(digs[idx]);
      m_k++;
      me  = minbtn && !p_min;
      se  = secbtn && !p_sec;
      pe  = pause && !p_pause;
      ste = start && !p_start;
      p_min = minbtn; p_sec = secbtn; p_pause = pause; p_start = start;
      lim  = zippy ? ZIP : TICK;
      step = (m_mode == M_RUN) && (m_el >= lim - 1);
      nxt  = m_mode;
      if (m_mode == M_RUN) begin
        if (step) begin
          if (count_up) begin
            m_total = (m_total < 3599) ? m_total + 1 : 3599;
          end else begin
            if (m_total > 0) m_total--;
            if (m_total == 0) nxt = M_DONE;
          end
        end
        if (nxt != M_DONE && pe) nxt = M_PAUSE;
      end else begin
        if (me || se) begin
          v  = (timesetter > 59) ? 59 : int'(timesetter);
          mm = m_total / 60;
          ss = m_total % 60;
          if (me) mm = v;
          if (se) ss = v;
          m_total = mm * 60 + ss;
        end
        if (m_mode == M_DONE) begin
          if (me || se) nxt = M_IDLE;
        end else if (!pe && ste) begin
          nxt = M_RUN;
        end
      end
      m_el   = (m_mode == M_RUN && nxt == M_RUN && !ste) ? (step ? 0 : m_el + 1) : 0;
      m_mode = nxt;
    end
    @(posedge clk);
    #1;
    chk("an", int'(AN), int'(e_an));
    chk("seven", int'(seven), int'(e_seven));
    chk("zled", int'(zled), (m_mode == M_DONE) ? 1 : 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_min(input logic [5:0] v);
    timesetter = v; minbtn = 1'b1; tick(); minbtn = 1'b0; tick();
  endtask

  task automatic pulse_sec(input logic [5:0] v);
    timesetter = v; secbtn = 1'b1; tick(); secbtn = 1'b0; tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0; tick();
  endtask

  task automatic pulse_pause();
    pause = 1'b1; tick(); pause = 1'b0; tick();
  endtask

  // Scan the display for a full refresh cycle and decode minutes and seconds.
  task automatic read_display(output int mm, output int ss);
    int d[4];
    for (int i = 0; i < 4; i++) d[i] = -1;
    for (int i = 0; i < 4 * REF + 2; i++) begin
      tick();
      case (AN)
        4'b1110: d[0] = dig_of(seven);
        4'b1101: d[1] = dig_of(seven);
        4'b1011: d[2] = dig_of(seven);
        4'b0111: d[3] = dig_of(seven);
        default: ;
      endcase
    end
    if (d[0] < 0 || d[1] < 0 || d[2] < 0 || d[3] < 0) begin
      mm = -1; ss = -1;
    end else begin
      mm = d[3] * 10 + d[2];
      ss = d[1] * 10 + d[0];
    end
  endtask

  initial begin
    int mm, ss, mm2, ss2;
    reset = 1'b1; minbtn = 1'b0; secbtn = 1'b0; pause = 1'b0; start = 1'b0;
    count_up = 1'b0; zippy = 1'b0; timesetter = 6'd0;
    m_total = 0; m_mode = M_IDLE; m_el = 0; m_k = 0;
    p_min = 1'b0; p_sec = 1'b0; p_pause = 1'b0; p_start = 1'b0;
    tick(); tick();
    chk("reset_an", int'(AN), 4'b1110);
    chk("reset_seven", int'(seven), 7'b1000000);
    chk("reset_zled", int'(zled), 0);
    reset = 1'b0;
    read_display(mm, ss);
    chk("reset_min", mm, 0);
    chk("reset_sec", ss, 0);

    // Loads, including saturation of an over-range switch value.
    pulse_min(6'd59);
    pulse_sec(6'd49);
    read_display(mm, ss);
    chk("load_min", mm, 59);
    chk("load_sec", ss, 49);
    pulse_min(6'd0);
    pulse_min(6'd63);
    read_display(mm, ss);
    chk("sat_min", mm, 59);

    // Count up to 59:59 and saturate while still running.
    count_up = 1'b1;
    pulse_start();
    run(12 * TICK);
    read_display(mm, ss);
    chk("up_sat_min", mm, 59);
    chk("up_sat_sec", ss, 59);
    chk("up_sat_zled", int'(zled), 0);

    // Zippy countdown across the minute borrow.
    zippy = 1'b1; count_up = 1'b0;
    run(62 * ZIP);
    pulse_pause();
    read_display(mm, ss);
    chk("zip_min", mm, 58);
    chk("zip_sec_model", ss, m_total % 60);

    // Countdown to DONE, DONE ignores start, a load leaves DONE.
    zippy = 1'b0;
    pulse_min(6'd0);
    pulse_sec(6'd2);
    pulse_start();
    run(2 * TICK + 2);
    chk("done_zled", int'(zled), 1);
    read_display(mm, ss);
    chk("done_sec", ss, 0);
    pulse_start();
    run(TICK + 5);
    chk("done_hold_zled", int'(zled), 1);
    pulse_sec(6'd5);
    chk("done_exit_zled", int'(zled), 0);
    read_display(mm, ss);
    chk("reload_sec", ss, 5);

    // Pause freezes the value; simultaneous start+pause stays paused.
    pulse_start();
    run(TICK + 10);
    pulse_pause();
    read_display(mm, ss);
    run(3 * TICK);
    read_display(mm2, ss2);
    chk("pause_hold", ss2, ss);
    start = 1'b1; pause = 1'b1; tick(); start = 1'b0; pause = 1'b0;
    run(2 * TICK);
    read_display(mm2, ss2);
    chk("start_pause_hold", ss2, ss);

    // Reset mid-run.
    pulse_start();
    run(10);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midreset_zled", int'(zled), 0);
    read_display(mm, ss);
    chk("midreset_min", mm, 0);
    chk("midreset_sec", ss, 0);

    // Randomized stimulus against the model.
    for (int i = 0; i < 6000; i++) begin
      minbtn     = ($urandom_range(0, 19) == 0);
      secbtn     = ($urandom_range(0, 19) == 0);
      start      = ($urandom_range(0, 11) == 0);
      pause      = ($urandom_range(0, 29) == 0);
      timesetter = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 63) == 0) count_up = ~count_up;
      zippy      = ($urandom_range(0, 9) != 0);
      reset      = ($urandom_range(0, 1499) == 0);
      tick();
    end
    reset = 1'b0; minbtn = 1'b0; secbtn = 1'b0; start = 1'b0; pause = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
